// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share one APB master port.
// Each accepted request becomes one APB transfer (SETUP then ACCESS).
// An ACCESS phase that runs TIMEOUT cycles without pready ends with an error response.
//
// Ports
//   pclk, presetn                  clock and asynchronous active-low reset
//   req_valid/write/addr/wdata     per-requester request; slice i of addr/wdata is [32i+31:32i]
//   req_ready                      combinational accept pulse to the granted requester (IDLE only)
//   rsp_valid/rdata/slverr         registered completion pulse to the owner, with its data and status
//   paddr/pwrite/pwdata/psel/penable  registered APB request signals
//   prdata/pready/pslverr          APB slave response
module apb_master_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0]      req_write,
  input  logic [32*NUM_REQ-1:0]   req_addr,
  input  logic [32*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [31:0]             rsp_rdata,
  output logic                    rsp_slverr,
  output logic [31:0]             paddr,
  output logic                    pwrite,
  output logic [31:0]             pwdata,
  output logic [15:0]             psel,
  output logic                    penable,
  input  logic [31:0]             prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = 8;
  localparam logic [NUM_REQ-1:0] REQ_ONE = NUM_REQ'(1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;   // current owner; doubles as last_grant
  logic [CNT_W-1:0]   wcnt_q, wcnt_d;
  logic [31:0]        paddr_d, pwdata_d, rsp_rdata_d;
  logic               pwrite_d, penable_d, rsp_slverr_d;
  logic [15:0]        psel_d;
  logic [NUM_REQ-1:0] rsp_valid_d;

  logic               gnt_found;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W-1:0]   cand;
  logic [31:0]        gnt_addr, gnt_wdata;
  logic               gnt_write;

  // Round-robin pick: scan from owner+1, wrapping, first valid request wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(owner_q) + k) % NUM_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    gnt_addr  = req_addr[32'(gnt_idx)*32 +: 32];
    gnt_wdata = req_wdata[32'(gnt_idx)*32 +: 32];
    gnt_write = req_write[gnt_idx];
  end

  // Next-state and next-output logic; req_ready is the only combinational output.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    wcnt_d       = wcnt_q;
    paddr_d      = paddr;
    pwrite_d     = pwrite;
    pwdata_d     = pwdata;
    psel_d       = psel;
    penable_d    = penable;
    rsp_valid_d  = '0;
    rsp_rdata_d  = rsp_rdata;
    rsp_slverr_d = rsp_slverr;
    req_ready    = '0;
    unique case (state_q)
      IDLE: begin
        if (gnt_found) begin
          // Gated by presetn so an asserted reset never shows an accept.
          req_ready = presetn ? (REQ_ONE << gnt_idx) : '0;
          state_d   = SETUP;
          owner_d   = gnt_idx;
          paddr_d   = gnt_addr;
          pwrite_d  = gnt_write;
          pwdata_d  = gnt_wdata;
          psel_d    = 16'h0001 << gnt_addr[31:28];
          penable_d = 1'b0;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        wcnt_d    = '0;
      end
      ACCESS: begin
        if (pready) begin
          state_d      = IDLE;
          psel_d       = '0;
          penable_d    = 1'b0;
          rsp_valid_d  = REQ_ONE << owner_q;
          rsp_slverr_d = pslverr;
          rsp_rdata_d  = pwrite ? 32'h0 : prdata;
        end else if (wcnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Slave never answered: abort and report an error with zero data.
          state_d      = IDLE;
          psel_d       = '0;
          penable_d    = 1'b0;
          rsp_valid_d  = REQ_ONE << owner_q;
          rsp_slverr_d = 1'b1;
          rsp_rdata_d  = 32'h0;
        end else begin
          wcnt_d = wcnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q    <= IDLE;
      owner_q    <= IDX_W'(NUM_REQ - 1);
      wcnt_q     <= '0;
      paddr      <= '0;
      pwrite     <= 1'b0;
      pwdata     <= '0;
      psel       <= '0;
      penable    <= 1'b0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_slverr <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      wcnt_q     <= wcnt_d;
      paddr      <= paddr_d;
      pwrite     <= pwrite_d;
      pwdata     <= pwdata_d;
      psel       <= psel_d;
      penable    <= penable_d;
      rsp_valid  <= rsp_valid_d;
      rsp_rdata  <= rsp_rdata_d;
      rsp_slverr <= rsp_slverr_d;
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter (NUM_REQ=2, TIMEOUT=16).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_apb_master_arbiter;

  localparam int unsigned NR = 2;

  logic           pclk;
  logic           presetn;
  logic [NR-1:0]  req_valid;
  logic [NR-1:0]  req_write;
  logic [32*NR-1:0] req_addr;
  logic [32*NR-1:0] req_wdata;
  logic [NR-1:0]  req_ready;
  logic [NR-1:0]  rsp_valid;
  logic [31:0]    rsp_rdata;
  logic           rsp_slverr;
  logic [31:0]    paddr;
  logic           pwrite;
  logic [31:0]    pwdata;
  logic [15:0]    psel;
  logic           penable;
  logic [31:0]    prdata;
  logic           pready;
  logic           pslverr;

  int n_cmp = 0;
  int n_err = 0;

  apb_master_arbiter #(.NUM_REQ(NR), .TIMEOUT(16)) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
    .psel(psel), .penable(penable),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge pclk);
    #1;
  endtask

  task automatic set_req(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
    req_write[i] = w;
    req_addr[32*i +: 32] = a;
    req_wdata[32*i +: 32] = d;
  endtask

  initial begin
    int acc_cycles;
    bit done;
    presetn = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    tick(); tick();
    // Reset state
    check("rst_psel", 32'(psel), 32'h0);
    check("rst_penable", 32'(penable), 32'h0);
    check("rst_paddr", paddr, 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rdata", rsp_rdata, 32'h0);
    presetn = 1'b1;
    tick();

    // Zero-wait read by requester 0
    set_req(0, 1'b0, 32'h3000_0010, 32'h0);
    req_valid = 2'b01; pready = 1'b1; prdata = 32'hCAFE_F00D;
    #1 check("rd_ready_T", 32'(req_ready), 32'h1);
    tick(); req_valid = 2'b00; #1;
    check("rd_psel_T1", 32'(psel), 32'h0008);
    check("rd_pen_T1", 32'(penable), 32'h0);
    check("rd_paddr_T1", paddr, 32'h3000_0010);
    check("rd_ready_busy", 32'(req_ready), 32'h0);
    tick();
    check("rd_psel_T2", 32'(psel), 32'h0008);
    check("rd_pen_T2", 32'(penable), 32'h1);
    tick();
    check("rd_rsp_valid", 32'(rsp_valid), 32'h1);
    check("rd_rdata", rsp_rdata, 32'hCAFE_F00D);
    check("rd_slverr", 32'(rsp_slverr), 32'h0);
    check("rd_psel_T3", 32'(psel), 32'h0);

    // Write by requester 1 with three wait states
    set_req(1, 1'b1, 32'h0000_0004, 32'h1234_5678);
    req_valid = 2'b10; pready = 1'b0; prdata = 32'hDEAD_BEEF;
    #1 check("wr_ready_T", 32'(req_ready), 32'h2);
    tick(); req_valid = 2'b00; #1;
    check("wr_psel_T1", 32'(psel), 32'h0001);
    check("wr_pen_T1", 32'(penable), 32'h0);
    for (int c = 2; c <= 5; c++) begin
      tick();
      if (c == 5) pready = 1'b1;
      check($sformatf("wr_pen_T%0d", c), 32'(penable), 32'h1);
      check($sformatf("wr_pwdata_T%0d", c), pwdata, 32'h1234_5678);
      check($sformatf("wr_rspv_T%0d", c), 32'(rsp_valid), 32'h0);
    end
    check("wr_rdata_hold", rsp_rdata, 32'hCAFE_F00D);
    tick();
    check("wr_rsp_valid", 32'(rsp_valid), 32'h2);
    check("wr_rdata", rsp_rdata, 32'h0);
    check("wr_slverr", 32'(rsp_slverr), 32'h0);
    check("wr_pen_T6", 32'(penable), 32'h0);

    // Timeout: pready stuck low
    pready = 1'b0;
    set_req(0, 1'b0, 32'hF000_0000, 32'h0);
    req_valid = 2'b01;
    #1 check("to_ready", 32'(req_ready), 32'h1);
    tick(); req_valid = 2'b00; #1;
    check("to_psel", 32'(psel), 32'h8000);
    acc_cycles = 0; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      if (rsp_valid != '0) done = 1'b1;
      else if (penable) acc_cycles++;
    end
    check("to_done", 32'(done), 32'h1);
    check("to_access_cycles", 32'(acc_cycles), 32'd16);
    check("to_rsp_valid", 32'(rsp_valid), 32'h1);
    check("to_slverr", 32'(rsp_slverr), 32'h1);
    check("to_rdata", rsp_rdata, 32'h0);
    check("to_psel_end", 32'(psel), 32'h0);

    // Slave error on a write, then a clean read
    pready = 1'b1; pslverr = 1'b1;
    set_req(1, 1'b1, 32'h1000_0000, 32'hA5A5_A5A5);
    req_valid = 2'b10;
    #1 check("se_ready", 32'(req_ready), 32'h2);
    tick(); req_valid = 2'b00; #1;
    check("se_psel", 32'(psel), 32'h0002);
    tick(); tick();
    check("se_rsp_valid", 32'(rsp_valid), 32'h2);
    check("se_slverr", 32'(rsp_slverr), 32'h1);
    pslverr = 1'b0; prdata = 32'h0000_55AA;
    set_req(0, 1'b0, 32'h2000_0000, 32'h0);
    req_valid = 2'b01;
    #1 check("ok_ready", 32'(req_ready), 32'h1);
    tick(); req_valid = 2'b00;
    tick(); tick();
    check("ok_rsp_valid", 32'(rsp_valid), 32'h1);
    check("ok_slverr", 32'(rsp_slverr), 32'h0);
    check("ok_rdata", rsp_rdata, 32'h0000_55AA);

    // Both requesting from reset: grants alternate 0,1,0,1
    presetn = 1'b0; req_valid = 2'b11; pready = 1'b1;
    set_req(0, 1'b0, 32'h1000_0000, 32'h0);
    set_req(1, 1'b0, 32'h2000_0000, 32'h0);
    tick();
    check("rr_ready_in_rst", 32'(req_ready), 32'h0);
    presetn = 1'b1;
    #1;
    for (int t = 0; t < 4; t++) begin
      check($sformatf("rr_ready_%0d", t), 32'(req_ready), (t % 2 == 0) ? 32'h1 : 32'h2);
      if (t > 0) check($sformatf("rr_rspv_%0d", t), 32'(rsp_valid), (t % 2 == 1) ? 32'h1 : 32'h2);
      tick();
      check($sformatf("rr_psel_%0d", t), 32'(psel), (t % 2 == 0) ? 32'h0002 : 32'h0004);
      tick();
      check($sformatf("rr_psel_acc_%0d", t), 32'(psel), (t % 2 == 0) ? 32'h0002 : 32'h0004);
      tick();
    end
    req_valid = 2'b00;
    tick();

    // Reset asserted in the second ACCESS cycle
    pready = 1'b0;
    set_req(1, 1'b0, 32'h5000_0000, 32'h0);
    req_valid = 2'b10;
    #1 check("ra_ready", 32'(req_ready), 32'h2);
    tick(); tick(); tick();
    check("ra_pen_before", 32'(penable), 32'h1);
    req_valid = 2'b11;
    presetn = 1'b0;
    #1;
    check("ra_psel", 32'(psel), 32'h0);
    check("ra_penable", 32'(penable), 32'h0);
    check("ra_paddr", paddr, 32'h0);
    check("ra_req_ready", 32'(req_ready), 32'h0);
    check("ra_rsp_valid", 32'(rsp_valid), 32'h0);
    tick();
    check("ra_rsp_valid2", 32'(rsp_valid), 32'h0);
    presetn = 1'b1;
    #1 check("ra_first_grant", 32'(req_ready), 32'h1);
    pready = 1'b1;
    tick(); req_valid = 2'b00;
    tick(); tick();
    check("ra_rsp_after", 32'(rsp_valid), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/apb_master_arbiter.md
APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requesters sharing the APB bus (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 16, maximum ACCESS-phase cycles before forced termination (2..255).
REQ-003 SHALL have ports:
- pclk  in  1  clock; all state changes on its rising edge.
- presetn  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester transfer request, held until accepted.
- req_write  in  NUM_REQ  per-requester direction (1 = write).
- req_addr  in  32*NUM_REQ  per-requester address; slice i = bits [32i+31:32i].
- req_wdata  in  32*NUM_REQ  per-requester write data, same slicing.
- req_ready  out  NUM_REQ  one-cycle accept pulse to the granted requester.
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owning requester.
- rsp_rdata  out  32  read data, valid with rsp_valid.
- rsp_slverr  out  1  error flag, valid with rsp_valid.
- paddr  out  32  APB address.
- pwrite  out  1  APB direction.
- pwdata  out  32  APB write data.
- psel  out  16  APB one-hot slave select.
- penable  out  1  APB enable.
- prdata  in  32  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.

Function
REQ-004 SHALL implement FSM states IDLE, SETUP, ACCESS; all outputs driven from registers.
REQ-005 IDLE: if any req_valid is high, the arbiter SHALL grant one requester, assert its req_ready for that cycle only (combinational from state and req_valid), latch its addr/write/wdata and index, and go to SETUP.
REQ-006 Arbitration SHALL be round-robin: priority starts at (last_grant+1) mod NUM_REQ; after reset, last_grant = NUM_REQ-1, so requester 0 has top priority.
REQ-007 SETUP: psel SHALL be one-hot at bit paddr[31:28], penable=0, paddr/pwrite/pwdata = latched values; next state ACCESS unconditionally.
REQ-008 ACCESS: penable=1 and psel, paddr, pwrite, pwdata held unchanged; SHALL remain in ACCESS while pready=0, up to the timeout.
REQ-009 On a rising edge in ACCESS with pready=1: go to IDLE; next cycle rsp_valid[owner]=1, rsp_slverr=pslverr, rsp_rdata=prdata for reads and 0 for writes.
REQ-010 Wait counter SHALL clear on entering ACCESS and increment on each ACCESS cycle with pready=0.
REQ-011 If pready=0 and wait counter = TIMEOUT-1: terminate to IDLE; next cycle rsp_valid[owner]=1, rsp_slverr=1, rsp_rdata=0.
REQ-012 If pready=1 in the cycle the timeout would fire, SHALL treat it as normal completion (REQ-009).
REQ-013 In IDLE: psel=0 and penable=0; paddr/pwrite/pwdata SHALL hold their last values.
REQ-014 Timing: zero-wait transfer accepted in cycle T gives SETUP at T+1, ACCESS at T+2, rsp_valid at T+3; the next accept is possible at T+3.
REQ-015 req_ready and rsp_valid SHALL each be one-hot or zero; req_ready is 0 outside IDLE.
REQ-016 rsp_rdata and rsp_slverr SHALL hold their last values when rsp_valid=0.
REQ-017 Requests arriving while not in IDLE SHALL wait; requester inputs are ignored until their grant.

Reset
REQ-018 presetn low SHALL immediately force: state IDLE, psel=0, penable=0, paddr=0, pwrite=0, pwdata=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_slverr=0, wait counter 0, last_grant=NUM_REQ-1.
REQ-019 Reset during SETUP or ACCESS SHALL abandon the transfer with no rsp_valid; the requester must re-request.

Verification
REQ-020 Requester 0 reads 0x3000_0010 with pready=1, prdata=0xCAFE_F00D -> req_ready[0] at T; psel=16'h0008 at T+1/T+2 (penable at T+2); rsp_valid[0], rsp_rdata=0xCAFE_F00D, rsp_slverr=0 at T+3.
REQ-021 Requester 1 writes 0x0000_0004 / 0x1234_5678 with 3 wait states -> ACCESS lasts 4 cycles; pwdata stable; rsp_valid[1], rsp_rdata=0 at T+6.
REQ-022 Both req_valid high from reset -> grant order 0,1,0,1 over four transfers, with no overlap of psel.
REQ-023 pready stuck 0 with TIMEOUT=16 -> exactly 16 ACCESS cycles, then rsp_valid, rsp_slverr=1, rsp_rdata=0, psel=0.
REQ-024 presetn asserted in the second ACCESS cycle -> psel, penable and all outputs 0 at once; no rsp_valid; requester 0 granted first after reset.
REQ-025 pslverr=1 with pready=1 on a write -> rsp_slverr=1; the next transfer completes with rsp_slverr=0.
